keyboard_fifo: RTL

Upstream feeder for the processor's keyboard input path. It receives PS/2 keyboard frames, checks them, optionally drops key-release sequences, and buffers the scan codes in a FIFO. The head of the FIFO is presented to the processor on `keyboard_in`. The processor's input instruction pops one entry by asserting `keyboard_ack`.

---
 rtl/keyboard_fifo_pkg.sv | 25 ++
 rtl/keyboard_fifo_ps2_rx.sv | 148 ++++++++++++++
 rtl/keyboard_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/keyboard_fifo_pkg.sv
// -----------------------------------------------------------------------------
// keyboard_fifo_pkg
// Shared definitions for the PS/2 keyboard input path: frame bit constants,
// scan-code constants, the receiver state encoding and a parity helper.
// -----------------------------------------------------------------------------
package keyboard_fifo_pkg;

    localparam logic       PS2_START_BIT = 1'b0;
    localparam logic       PS2_STOP_BIT  = 1'b1;
    localparam logic [7:0] BREAK_CODE    = 8'hF0;
    localparam logic [7:0] EXT_CODE      = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/keyboard_fifo_ps2_rx.sv
// -----------------------------------------------------------------------------
// keyboard_fifo_ps2_rx
// PS/2 frame receiver: synchronises the raw PS/2 clock/data, detects falling
// edges of the PS/2 clock and runs the frame FSM (start, 8 data bits LSB
// first, odd parity, stop). A partial frame is abandoned after TIMEOUT cycles
// without a falling edge.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      synchronous active-low reset
//   i_ps2_clk    raw PS/2 clock (asynchronous)
//   i_ps2_data   raw PS/2 data  (asynchronous)
//   o_byte       last good received byte
//   o_byte_valid one-cycle pulse: o_byte holds a freshly received good byte
//   o_err_pulse  one-cycle pulse: bad start/parity/stop or timeout
// -----------------------------------------------------------------------------
module keyboard_fifo_ps2_rx #(
    parameter int TIMEOUT = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err_pulse
);
    import keyboard_fifo_pkg::*;

    localparam int             TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_prev;
    rx_state_t     r_state;
    rx_state_t     w_state_next;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;
    logic          r_parity;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic          r_err_pulse;
    logic          w_fall;
    logic          w_data;
    logic          w_timeout;
    logic          w_valid_next;
    logic          w_err_next;

    // Two-flop synchronisers plus one history flop for edge detection.
    // Idle PS/2 lines are high, so the flops reset to 1 to avoid a false edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[1];
    assign w_data = r_data_sync[1];

    // Timeout only fires on a cycle with no falling edge, so a late edge
    // arriving exactly at the limit still completes the frame.
    assign w_timeout = (r_state != IDLE) && !w_fall && (r_timer == TIMER_LAST);

    // State register and frame datapath.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_shift      <= 8'd0;
            r_bit_idx    <= 3'd0;
            r_parity     <= 1'b0;
            r_timer      <= '0;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_byte_valid <= w_valid_next;
            r_err_pulse  <= w_err_next;
            if (w_valid_next) begin
                r_byte <= r_shift;
            end
            if (r_state == IDLE || w_fall) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    IDLE:    r_bit_idx <= 3'd0;
                    DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    PARITY:  r_parity  <= w_data;
                    default: ;
                endcase
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    if (w_data == PS2_START_BIT) w_state_next = DATA;
                DATA:    if (r_bit_idx == 3'd7)       w_state_next = PARITY;
                PARITY:  w_state_next = STOP;
                STOP:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Output decode: frame verdict is taken on the stop-bit edge.
    always_comb begin
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        if (w_timeout) begin
            w_err_next = 1'b1;
        end else if (w_fall) begin
            if (r_state == IDLE && w_data != PS2_START_BIT) begin
                w_err_next = 1'b1;
            end else if (r_state == STOP) begin
                if (w_data == PS2_STOP_BIT && odd_parity_ok(r_shift, r_parity)) begin
                    w_valid_next = 1'b1;
                end else begin
                    w_err_next = 1'b1;
                end
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_err_pulse  = r_err_pulse;

endmodule

// File: rtl/keyboard_fifo.sv
// -----------------------------------------------------------------------------
// keyboard_fifo
// Keyboard input feeder: PS/2 receiver, optional break-code filter and a
// scan-code FIFO whose head is presented to the processor as a registered
// 32-bit value.
//
// Ports:
//   clock         system clock
//   reset         synchronous active-low reset
//   ps2_clk       raw PS/2 clock (asynchronous)
//   ps2_data      raw PS/2 data  (asynchronous)
//   keyboard_ack  pop request from the processor's input instruction
//   keyboard_in   head entry zero-extended, 0 when empty
//   fifo_count    number of entries held
//   overflow      sticky: a byte arrived while full and was dropped
//   frame_error   sticky: a bad or timed-out frame was seen
// -----------------------------------------------------------------------------
module keyboard_fifo #(
    parameter int DEPTH        = 8,
    parameter int TIMEOUT      = 50000,
    parameter int FILTER_BREAK = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     keyboard_ack,
    output logic [31:0]              keyboard_in,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_error
);
    import keyboard_fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_head;
    logic          r_skip;
    logic          r_overflow;
    logic          r_frame_error;

    logic [7:0]    w_rx_byte;
    logic          w_rx_valid;
    logic          w_rx_err;
    logic          w_push;
    logic          w_skip_next;
    logic          w_full;
    logic          w_pop;
    logic          w_push_acc;
    logic          w_drop;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] w_count_next;
    logic [7:0]    w_head_next;

    keyboard_fifo_ps2_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_ps2_rx (
        .i_clk        (clock),
        .i_rst_n      (reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_rx_byte),
        .o_byte_valid (w_rx_valid),
        .o_err_pulse  (w_rx_err)
    );

    // Break filter: 0xF0 and the byte after it are swallowed. Extended
    // prefix 0xE0 is treated like any ordinary make code.
    always_comb begin
        w_push      = 1'b0;
        w_skip_next = r_skip;
        if (w_rx_valid) begin
            if (FILTER_BREAK != 0) begin
                if (r_skip) begin
                    w_skip_next = 1'b0;
                end else if (w_rx_byte == BREAK_CODE) begin
                    w_skip_next = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end else begin
                w_push = 1'b1;
            end
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when the processor acknowledges at the same time.
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_pop        = keyboard_ack && (r_count != '0);
    assign w_push_acc   = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_rd_next    = r_rd_ptr + AW'(w_pop);
    assign w_count_next = r_count + CW'(w_push_acc) - CW'(w_pop);

    // The head register tracks the entry at the post-update read pointer;
    // when that slot is the one being written this cycle, bypass the array.
    always_comb begin
        w_head_next = 8'd0;
        if (w_count_next != '0) begin
            if (w_push_acc && (r_wr_ptr == w_rd_next)) begin
                w_head_next = w_rx_byte;
            end else begin
                w_head_next = r_mem[w_rd_next];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= w_rx_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_head        <= 8'd0;
            r_skip        <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_skip   <= w_skip_next;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_rx_err) begin
                r_frame_error <= 1'b1;
            end
        end
    end

    assign keyboard_in = {24'd0, r_head};
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign frame_error = r_frame_error;

endmodule
